// File: rtl/sum_window_accum.sv
// Sliding-window sum over the last DEPTH lane totals, with restart (ld) and async reset.
// Optional output saturation when the accumulator is wider than sum_out: define SUM_WINDOW_SAT_EN.
module sum_window_accum #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LANES  = 2,
    parameter int unsigned DEPTH  = 5,
    parameter int unsigned SUM_W  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           ld,
    input  logic [LANES*DATA_W-1:0]        data_in,
    output logic [SUM_W-1:0]               sum_out,
    output logic                           valid_out,
    output logic [$clog2(DEPTH+1)-1:0]     fill_cnt
);

    localparam int unsigned TW = DATA_W + $clog2(LANES);
    localparam int unsigned AW = TW + $clog2(DEPTH);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned FW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FILL  = 2'd1,
        S_FULL  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [FW-1:0]   fill_q, fill_d;
    logic [SUM_W-1:0] sum_q;
    logic            valid_q;
    logic [TW-1:0]   hist_q [DEPTH];

    logic [TW-1:0]   total_c;
    logic [PW-1:0]   ptr_nxt_c;
    logic [PW-1:0]   hist_wptr_c;
    logic            hist_we_c;
    logic            hist_clr_c;
    logic [SUM_W-1:0] sum_fmt_c;

    // Lossless sum of all lanes for the current sample
    always_comb begin
        total_c = '0;
        for (int k = 0; k < LANES; k++) begin
            total_c = total_c + TW'(data_in[k*DATA_W +: DATA_W]);
        end
    end

    assign ptr_nxt_c = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);

    // Next-state and datapath control; ld outranks en
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ptr_d       = ptr_q;
        fill_d      = fill_q;
        hist_we_c   = 1'b0;
        hist_clr_c  = 1'b0;
        hist_wptr_c = ptr_q;

        if (ld) begin
            acc_d       = AW'(total_c);
            ptr_d       = PW'(1);
            fill_d      = FW'(1);
            state_d     = S_FILL;
            hist_clr_c  = 1'b1;
            hist_we_c   = 1'b1;
            hist_wptr_c = '0;
        end else if (en) begin
            case (state_q)
                S_EMPTY, S_FILL: begin
                    acc_d     = acc_q + AW'(total_c);
                    hist_we_c = 1'b1;
                    ptr_d     = ptr_nxt_c;
                    fill_d    = fill_q + FW'(1);
                    state_d   = (fill_q + FW'(1) == FW'(DEPTH)) ? S_FULL : S_FILL;
                end
                S_FULL: begin
                    // ptr_q addresses the oldest entry once the window is full
                    acc_d     = acc_q + AW'(total_c) - AW'(hist_q[ptr_q]);
                    hist_we_c = 1'b1;
                    ptr_d     = ptr_nxt_c;
                end
                default: begin
                    state_d = S_EMPTY;
                end
            endcase
        end
    end

    // Map the exact accumulator onto the sum_out width
    generate
        if (AW > SUM_W) begin : g_narrow
`ifdef SUM_WINDOW_SAT_EN
            assign sum_fmt_c = (acc_d > AW'({SUM_W{1'b1}})) ? {SUM_W{1'b1}} : acc_d[SUM_W-1:0];
`else
            assign sum_fmt_c = acc_d[SUM_W-1:0];
`endif
        end else begin : g_wide
            assign sum_fmt_c = SUM_W'(acc_d);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_EMPTY;
            acc_q   <= '0;
            ptr_q   <= '0;
            fill_q  <= '0;
            sum_q   <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ptr_q   <= ptr_d;
            fill_q  <= fill_d;
            sum_q   <= sum_fmt_c;
            valid_q <= (state_d == S_FULL);
            if (hist_clr_c) begin
                for (int i = 0; i < DEPTH; i++) begin
                    hist_q[i] <= '0;
                end
            end
            if (hist_we_c) begin
                hist_q[hist_wptr_c] <= total_c;
            end
        end
    end

    assign sum_out   = sum_q;
    assign valid_out = valid_q;
    assign fill_cnt  = fill_q;

endmodule

// File: tb/tb_sum_window_accum.sv
// Directed bench for sum_window_accum at DATA_W=8, LANES=2, DEPTH=4, SUM_W=10.
module tb_sum_window_accum;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned LANES  = 2;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned SUM_W  = 10;
    localparam int unsigned FW     = $clog2(DEPTH + 1);

`ifdef SUM_WINDOW_SAT_EN
    localparam int unsigned SUM_2040 = 1023;
    localparam int unsigned SUM_1530 = 1023;
`else
    localparam int unsigned SUM_2040 = 1016;
    localparam int unsigned SUM_1530 = 506;
`endif

    logic                     clk;
    logic                     rst;
    logic                     en;
    logic                     ld;
    logic [LANES*DATA_W-1:0]  data_in;
    logic [SUM_W-1:0]         sum_out;
    logic                     valid_out;
    logic [FW-1:0]            fill_cnt;

    int unsigned n_vec;
    int unsigned n_bad;

    sum_window_accum #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .DEPTH  (DEPTH),
        .SUM_W  (SUM_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .ld        (ld),
        .data_in   (data_in),
        .sum_out   (sum_out),
        .valid_out (valid_out),
        .fill_cnt  (fill_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, then check all three outputs
    task automatic apply(input string tag, input logic e, input logic l,
                         input int unsigned l0, input int unsigned l1,
                         input int unsigned exp_sum, input int unsigned exp_fill,
                         input int unsigned exp_valid);
        en      = e;
        ld      = l;
        data_in = {8'(l1), 8'(l0)};
        @(posedge clk);
        #1;
        check({tag, ".sum"},   32'(sum_out),   exp_sum);
        check({tag, ".fill"},  32'(fill_cnt),  exp_fill);
        check({tag, ".valid"}, 32'(valid_out), exp_valid);
    endtask

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        rst     = 1'b1;
        en      = 1'b0;
        ld      = 1'b0;
        data_in = '0;
        #12;
        check("rst.sum",   32'(sum_out),   0);
        check("rst.fill",  32'(fill_cnt),  0);
        check("rst.valid", 32'(valid_out), 0);
        rst = 1'b0;

        // Constant lanes 10,20
        apply("c1", 1'b1, 1'b0, 10, 20,  30, 1, 0);
        apply("c2", 1'b1, 1'b0, 10, 20,  60, 2, 0);
        apply("c3", 1'b1, 1'b0, 10, 20,  90, 3, 0);
        apply("c4", 1'b1, 1'b0, 10, 20, 120, 4, 1);
        apply("c5", 1'b1, 1'b0, 10, 20, 120, 4, 1);
        apply("c6", 1'b1, 1'b0, 10, 20, 120, 4, 1);

        // Asynchronous reset mid-cycle, held across an edge with en=1
        #2;
        rst = 1'b1;
        #1;
        check("arst.sum",   32'(sum_out),   0);
        check("arst.fill",  32'(fill_cnt),  0);
        check("arst.valid", 32'(valid_out), 0);
        @(posedge clk);
        #1;
        check("arst_edge.sum",  32'(sum_out),  0);
        check("arst_edge.fill", 32'(fill_cnt), 0);
        #3;
        rst = 1'b0;

        // Totals 1..6 on lane 0
        apply("t1", 1'b1, 1'b0, 1, 0,  1, 1, 0);
        apply("t2", 1'b1, 1'b0, 2, 0,  3, 2, 0);
        apply("t3", 1'b1, 1'b0, 3, 0,  6, 3, 0);
        apply("t4", 1'b1, 1'b0, 4, 0, 10, 4, 1);
        apply("t5", 1'b1, 1'b0, 5, 0, 14, 4, 1);
        apply("t6", 1'b1, 1'b0, 6, 0, 18, 4, 1);

        // Restart from FULL, then continue
        apply("ld7",  1'b1, 1'b1, 7, 0, 7, 1, 0);
        apply("ld+1", 1'b1, 1'b0, 1, 0, 8, 2, 0);

        // ld with en=0 still restarts; then overflow of the 10-bit output
        apply("m1", 1'b0, 1'b1, 255, 255,      510, 1, 0);
        apply("m2", 1'b1, 1'b0, 255, 255,     1020, 2, 0);
        apply("m3", 1'b1, 1'b0, 255, 255, SUM_1530, 3, 0);
        apply("m4", 1'b1, 1'b0, 255, 255, SUM_2040, 4, 1);
        apply("h1", 1'b0, 1'b0,   0,   0, SUM_2040, 4, 1);
        apply("h2", 1'b0, 1'b0,   3,   9, SUM_2040, 4, 1);
        apply("h3", 1'b0, 1'b0,   0,   0, SUM_2040, 4, 1);

        // Slide out one 510 entry with a zero sample
        apply("z1", 1'b1, 1'b0, 0, 0, SUM_1530, 4, 1);
        apply("z2", 1'b1, 1'b0, 0, 0,     1020, 4, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
